// File: rtl/cart_unlock_seq.sv
// -----------------------------------------------------------------------------
// cart_unlock_seq
//
// Purpose:
//   Drives a cartridge through its unlock handshake. Each attempt holds the
//   cartridge in reset, lets it settle, presents two key addresses (5A, A5),
//   then shifts in a 20-bit response on SI and compares it with EXPECT. A
//   match ends in PASS, where the host address is passed straight through.
//   A mismatch retries the whole attempt up to MAX_RETRY times. After that,
//   the sequence parks in FAILED with the cartridge held in reset.
//
// Ports:
//   CLK          in   clock; all state changes on the rising edge
//   RSTn         in   asynchronous active-low reset
//   SI           in   cartridge serial output, LSB first; sampled only in RECV
//   ADDR_IN[7:0] in   host address, forwarded combinationally in PASS
//   CART_RSTn    out  cartridge reset, active-low
//   ADDR[7:0]    out  cartridge address bus (keys, then host address)
//   BUSY         out  sequence in progress (not PASS, not FAILED)
//   DONE         out  sequence finished (PASS or FAILED)
//   OK           out  unlock succeeded
//   FAIL         out  unlock gave up
//   CTRL1_B8     out  SYSTEM_CTRL1 bit 8 set request; sticky once set
//   RETRIES[1:0] out  retries taken so far; saturates at MAX_RETRY
//   dbg_state_o  out  current FSM state encoding, for observation only
//
// Handshake note: there is no valid/ready pair here. The cartridge side is
// purely time-slotted. SI is sampled on the 20 rising edges that end the
// RECV cycles and is ignored at every other time.
// -----------------------------------------------------------------------------
module cart_unlock_seq #(
  parameter int unsigned RST_CYCLES  = 8,
  parameter int unsigned START_DELAY = 2,
  parameter logic [19:0] EXPECT      = 20'h14503,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       SI,
  input  logic [7:0] ADDR_IN,
  output logic       CART_RSTn,
  output logic [7:0] ADDR,
  output logic       BUSY,
  output logic       DONE,
  output logic       OK,
  output logic       FAIL,
  output logic       CTRL1_B8,
  output logic [1:0] RETRIES,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    S_HOLD   = 3'd0,
    S_SETTLE = 3'd1,
    S_KEY1   = 3'd2,
    S_KEY2   = 3'd3,
    S_RECV   = 3'd4,
    S_CHECK  = 3'd5,
    S_PASS   = 3'd6,
    S_FAILED = 3'd7
  } state_t;

  // Terminal count of each timed state. A programmed length of 0 still
  // occupies one cycle, so its terminal count is 0 as well.
  localparam logic [15:0] HOLD_LAST   = 16'((RST_CYCLES  == 0) ? 0 : RST_CYCLES  - 1);
  localparam logic [15:0] SETTLE_LAST = 16'((START_DELAY == 0) ? 0 : START_DELAY - 1);
  localparam logic [15:0] RECV_LAST   = 16'd19;
  localparam logic [1:0]  MAX_R       = 2'(MAX_RETRY);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [19:0] rx_q, rx_d;
  logic [1:0]  retries_q, retries_d;
  logic        ctrl_q, ctrl_d;

  // State register and datapath registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= S_HOLD;
      cnt_q     <= '0;
      rx_q      <= '1;
      retries_q <= '0;
      ctrl_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      retries_q <= retries_d;
      ctrl_q    <= ctrl_d;
    end
  end

  // Next-state and datapath next values.
  always_comb begin
    state_d   = state_q;
    retries_d = retries_q;
    unique case (state_q)
      S_HOLD:   if (cnt_q == HOLD_LAST)   state_d = S_SETTLE;
      S_SETTLE: if (cnt_q == SETTLE_LAST) state_d = S_KEY1;
      S_KEY1:   state_d = S_KEY2;
      S_KEY2:   state_d = S_RECV;
      S_RECV:   if (cnt_q == RECV_LAST)   state_d = S_CHECK;
      S_CHECK: begin
        if (rx_q == EXPECT) begin
          state_d = S_PASS;
        end else if (retries_q < MAX_R) begin
          state_d   = S_HOLD;
          retries_d = retries_q + 2'd1;
        end else begin
          state_d = S_FAILED;
        end
      end
      default:  state_d = state_q;  // PASS and FAILED are terminal
    endcase

    // The counter restarts on every state change. It runs only in the timed
    // states, so the terminal states do not keep toggling it.
    if ((state_d != state_q) ||
        !((state_q == S_HOLD) || (state_q == S_SETTLE) || (state_q == S_RECV)))
      cnt_d = '0;
    else
      cnt_d = cnt_q + 16'd1;

    // The shift register is preloaded with ones on the edge entering KEY1,
    // so no bit from an earlier attempt survives into CHECK. In RECV, each
    // new sample enters at bit 19, and the first sample reaches bit 0 after
    // 20 shifts.
    if ((state_d == S_KEY1) && (state_q != S_KEY1))
      rx_d = '1;
    else if (state_q == S_RECV)
      rx_d = {SI, rx_q[19:1]};
    else
      rx_d = rx_q;

    // Set on the edge entering PASS. After that, only reset clears it.
    ctrl_d = ctrl_q | ((state_d == S_PASS) && (state_q != S_PASS));
  end

  // Outputs, decoded from the current state only. The only exception is
  // ADDR in PASS, which forwards ADDR_IN with no register stage.
  always_comb begin
    CART_RSTn = 1'b1;
    ADDR      = 8'h00;
    BUSY      = 1'b1;
    DONE      = 1'b0;
    OK        = 1'b0;
    FAIL      = 1'b0;
    unique case (state_q)
      S_HOLD:   CART_RSTn = 1'b0;
      S_SETTLE: ADDR = 8'h00;
      S_KEY1:   ADDR = 8'h5A;
      S_KEY2:   ADDR = 8'hA5;
      S_RECV:   ADDR = 8'h00;
      S_CHECK:  ADDR = 8'h00;
      S_PASS: begin
        ADDR = ADDR_IN;
        BUSY = 1'b0;
        DONE = 1'b1;
        OK   = 1'b1;
      end
      S_FAILED: begin
        CART_RSTn = 1'b0;
        BUSY      = 1'b0;
        DONE      = 1'b1;
        FAIL      = 1'b1;
      end
      default:  CART_RSTn = 1'b0;
    endcase
  end

  assign CTRL1_B8    = ctrl_q;
  assign RETRIES     = retries_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cart_unlock_seq.sv
// -----------------------------------------------------------------------------
// tb_cart_unlock_seq
//
// Self-checking bench for cart_unlock_seq with default parameters.
//
// The cartridge model reacts to the bus like a real cartridge. When it sees
// ADDR=A5, it drives the 20 response bits of the current attempt (LSB first)
// during the following 20 cycles. At all other times it drives idle or noise.
//
// The reference model predicts every output in every cycle from the cycle
// number counted since reset release. Each attempt is a fixed-length slot.
// The outcome depends on which attempt first presents the correct stream.
// -----------------------------------------------------------------------------
module tb_cart_unlock_seq;

  localparam logic [19:0] EXPECT = 20'h14503;
  localparam int R       = 8;   // HOLD length
  localparam int S       = 2;   // SETTLE length
  localparam int MAXR    = 3;
  localparam int ATT_LEN = R + S + 2 + 20 + 1;

  // ---------------- clock / reset ----------------
  logic       CLK = 1'b0;
  logic       RSTn;
  logic       SI;
  logic [7:0] ADDR_IN;
  logic       CART_RSTn, BUSY, DONE, OK, FAIL, CTRL1_B8;
  logic [7:0] ADDR;
  logic [1:0] RETRIES;
  logic [2:0] dbg_state;

  always #5 CLK = ~CLK;

  cart_unlock_seq dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .SI         (SI),
    .ADDR_IN    (ADDR_IN),
    .CART_RSTn  (CART_RSTn),
    .ADDR       (ADDR),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .OK         (OK),
    .FAIL       (FAIL),
    .CTRL1_B8   (CTRL1_B8),
    .RETRIES    (RETRIES),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- cartridge model state ----------------
  logic [19:0] streams [4];
  bit          noise;
  logic        idle_si;
  int          cart_att;
  int          bits_left;
  int          a5_seen;
  int          pass_k;

  function automatic int first_pass();
    for (int k = 0; k <= MAXR; k++)
      if (streams[k] == EXPECT) return k;
    return -1;
  endfunction

  // Reference model: expected outputs in cycle t after reset release.
  // st = {BUSY, DONE, OK, FAIL, CTRL1_B8}
  task automatic model(input int t, input logic [7:0] ain, output logic crst,
                       output logic [7:0] addr, output logic [4:0] st,
                       output logic [1:0] ret);
    int k, o;
    if (pass_k >= 0 && t >= ATT_LEN * (pass_k + 1)) begin
      crst = 1'b1; addr = ain; st = 5'b01101; ret = 2'(pass_k);
    end else if (pass_k < 0 && t >= ATT_LEN * (MAXR + 1)) begin
      crst = 1'b0; addr = 8'h00; st = 5'b01010; ret = 2'(MAXR);
    end else begin
      k    = t / ATT_LEN;
      o    = t % ATT_LEN;
      ret  = 2'(k);
      st   = 5'b10000;
      crst = (o >= R);
      addr = (o == R + S) ? 8'h5A : (o == R + S + 1) ? 8'hA5 : 8'h00;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_crst"},   {31'd0, CART_RSTn}, 32'd0);
    check({tag, "_addr"},   {24'd0, ADDR}, 32'd0);
    check({tag, "_status"}, {27'd0, BUSY, DONE, OK, FAIL, CTRL1_B8}, 32'h10);
    check({tag, "_retries"}, {30'd0, RETRIES}, 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  // Assert reset at a falling edge, check the reset values, then release.
  // The bench is left 1 time unit after the release edge.
  task automatic do_reset();
    @(negedge CLK);
    RSTn = 1'b0;
    #1;
    check_reset_values("reset");
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    #1;
  endtask

  // Runs n cycles from a fresh reset release, checking every output in every
  // cycle. If pairs_chk is set, the bench also checks the number of key
  // exchanges the cartridge saw.
  task automatic run_seq(input int n, input bit pairs_chk);
    logic       e_crst;
    logic [7:0] e_addr;
    logic [4:0] e_st;
    logic [1:0] e_ret;
    cart_att  = 0;
    bits_left = 0;
    a5_seen   = 0;
    pass_k    = first_pass();
    for (int t = 0; t < n; t++) begin
      if (pass_k >= 0 && t >= ATT_LEN * (pass_k + 1))
        ADDR_IN = 8'hC0 + 8'(t & 3);
      else
        ADDR_IN = 8'($urandom_range(0, 8'h4F));  // never a key value
      #1;
      model(t, ADDR_IN, e_crst, e_addr, e_st, e_ret);
      check($sformatf("c%0d_crst", t), {31'd0, CART_RSTn}, {31'd0, e_crst});
      check($sformatf("c%0d_addr", t), {24'd0, ADDR}, {24'd0, e_addr});
      check($sformatf("c%0d_status", t), {27'd0, BUSY, DONE, OK, FAIL, CTRL1_B8},
            {27'd0, e_st});
      check($sformatf("c%0d_retries", t), {30'd0, RETRIES}, {30'd0, e_ret});
      // Cartridge: shift out the armed response, otherwise idle or noise.
      if (bits_left > 0) begin
        SI = streams[(cart_att - 1) > 3 ? 3 : (cart_att - 1)][20 - bits_left];
        bits_left--;
      end else begin
        SI = noise ? 1'($urandom) : idle_si;
      end
      if (ADDR == 8'hA5) begin
        a5_seen++;
        cart_att++;
        bits_left = 20;
      end
      @(negedge CLK);
      #1;
    end
    if (pairs_chk) begin
      exp_q.push_back((pass_k >= 0) ? 32'(pass_k + 1) : 32'(MAXR + 1));
      check("key_pairs", 32'(a5_seen), exp_q.pop_front());
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RSTn    = 1'b0;
    SI      = 1'b0;
    ADDR_IN = 8'h00;
    noise   = 1'b0;
    idle_si = 1'b0;

    // Good cartridge on the first attempt. The run extends into PASS and
    // steps ADDR_IN through C0..C3.
    for (int k = 0; k < 4; k++) streams[k] = EXPECT;
    do_reset();
    run_seq(45, 1'b1);

    // SI stuck at 1: four full attempts, then FAILED.
    for (int k = 0; k < 4; k++) streams[k] = 20'hFFFFF;
    idle_si = 1'b1;
    do_reset();
    run_seq(140, 1'b1);
    idle_si = 1'b0;

    // Bit 5 wrong on the first attempt, correct on the second.
    streams[0] = EXPECT ^ 20'h00020;
    for (int k = 1; k < 4; k++) streams[k] = EXPECT;
    do_reset();
    run_seq(75, 1'b1);

    // Reset pulse in RECV cycle 10, then a fresh full sequence.
    for (int k = 0; k < 4; k++) streams[k] = EXPECT;
    do_reset();
    run_seq(R + S + 2 + 10, 1'b0);
    RSTn = 1'b0;
    #1;
    check_reset_values("mid_recv_abort");
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    #1;
    run_seq(45, 1'b1);

    // Reset while in PASS clears everything, including the sticky bit.
    RSTn = 1'b0;
    #1;
    check_reset_values("pass_abort");
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    #1;

    // Noise on SI outside RECV has no effect.
    noise = 1'b1;
    run_seq(45, 1'b1);

    // Randomised attempt outcomes.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 2))
          0:       streams[k] = EXPECT;
          1:       streams[k] = EXPECT ^ (20'h1 << $urandom_range(0, 19));
          default: streams[k] = 20'($urandom);
        endcase
      end
      noise = 1'($urandom);
      do_reset();
      run_seq(140, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
